// File: rtl/apb_master_param.sv
// rtl/apb_master_param.sv - parametrised APB4 master with strobes, error capture,
// wait-state timeout and back-to-back transfers.
module apb_master_param #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_W          = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [SEL_W-1:0]             req_sel,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [DATA_W/8-1:0]          req_strb,
  output logic                         resp_valid,
  output logic [DATA_W-1:0]            resp_rdata,
  output logic                         resp_err,
  output logic                         resp_timeout,
  output logic [NUM_SLAVES-1:0]        psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [ADDR_W-1:0]            paddr,
  output logic [DATA_W-1:0]            pwdata,
  output logic [DATA_W/8-1:0]          pstrb,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]        pready,
  input  logic [NUM_SLAVES-1:0]        pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        wait_q, wait_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]       paddr_q, paddr_d;
  logic [DATA_W-1:0]       pwdata_q, pwdata_d;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_err_q, resp_err_d;
  logic                    resp_timeout_q, resp_timeout_d;
  logic [DATA_W-1:0]       resp_rdata_q, resp_rdata_d;

  logic                    sel_ready, sel_err;
  logic [DATA_W-1:0]       sel_rdata;
  logic [NUM_SLAVES-1:0]   req_onehot;
  logic                    req_sel_ok;
  logic                    timeout_hit;
  logic                    ready_c;
  logic                    accept;

  // psel_q is one-hot during SETUP/ACCESS, so it doubles as the response mux select
  always_comb begin
    sel_ready  = 1'b0;
    sel_err    = 1'b0;
    sel_rdata  = '0;
    req_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (psel_q[i]) begin
        sel_ready = sel_ready | pready[i];
        sel_err   = sel_err | pslverr[i];
        sel_rdata = sel_rdata | prdata[i*DATA_W +: DATA_W];
      end
      req_onehot[i] = (32'(req_sel) == i);
    end
  end

  assign req_sel_ok  = (32'(req_sel) < NUM_SLAVES);
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && !sel_ready &&
                       (32'(wait_q) == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    psel_d         = psel_q;
    penable_d      = penable_q;
    pwrite_d       = pwrite_q;
    paddr_d        = paddr_q;
    pwdata_d       = pwdata_q;
    pstrb_d        = pstrb_q;
    resp_valid_d   = 1'b0;
    resp_err_d     = 1'b0;
    resp_timeout_d = 1'b0;
    resp_rdata_d   = resp_rdata_q;
    ready_c        = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        if (sel_ready) begin
          resp_valid_d = 1'b1;
          resp_err_d   = sel_err;
          if (!pwrite_q) resp_rdata_d = sel_rdata;
          // An invalid index is held off to IDLE so its error response cannot collide
          ready_c   = !(req_valid && !req_sel_ok);
          state_d   = S_IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
        end else if (timeout_hit) begin
          resp_valid_d   = 1'b1;
          resp_err_d     = 1'b1;
          resp_timeout_d = 1'b1;
          resp_rdata_d   = '0;
          state_d        = S_IDLE;
          psel_d         = '0;
          penable_d      = 1'b0;
        end else if (!sel_ready) begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase

    accept = ready_c && req_valid;
    if (accept) begin
      if (req_sel_ok) begin
        state_d   = S_SETUP;
        wait_d    = '0;
        psel_d    = req_onehot;
        penable_d = 1'b0;
        pwrite_d  = req_write;
        paddr_d   = req_addr;
        pwdata_d  = req_write ? req_wdata : pwdata_q;
        pstrb_d   = req_write ? req_strb : '0;
      end else begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      wait_q         <= '0;
      psel_q         <= '0;
      penable_q      <= 1'b0;
      pwrite_q       <= 1'b0;
      paddr_q        <= '0;
      pwdata_q       <= '0;
      pstrb_q        <= '0;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_rdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      psel_q         <= psel_d;
      penable_q      <= penable_d;
      pwrite_q       <= pwrite_d;
      paddr_q        <= paddr_d;
      pwdata_q       <= pwdata_d;
      pstrb_q        <= pstrb_d;
      resp_valid_q   <= resp_valid_d;
      resp_err_q     <= resp_err_d;
      resp_timeout_q <= resp_timeout_d;
      resp_rdata_q   <= resp_rdata_d;
    end
  end

  assign req_ready    = ready_c & reset_n;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign resp_timeout = resp_timeout_q;
  assign psel         = psel_q;
  assign penable      = penable_q;
  assign pwrite       = pwrite_q;
  assign paddr        = paddr_q;
  assign pwdata       = pwdata_q;
  assign pstrb        = pstrb_q;

endmodule

// File: tb/tb_apb_master_param.sv
// tb/tb_apb_master_param.sv - scoreboard bench for apb_master_param with a
// behavioural slave model and transaction-level response model.
module tb_apb_master_param;
  localparam int NS = 4;
  localparam int SW = 3;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req_valid, req_ready, req_write;
  logic [SW-1:0]     req_sel;
  logic [31:0]       req_addr, req_wdata;
  logic [3:0]        req_strb;
  logic              resp_valid, resp_err, resp_timeout;
  logic [31:0]       resp_rdata;
  logic [NS-1:0]     psel;
  logic              penable, pwrite;
  logic [31:0]       paddr, pwdata;
  logic [3:0]        pstrb;
  logic [NS*32-1:0]  prdata;
  logic [NS-1:0]     pready, pslverr;

  apb_master_param #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(NS), .SEL_W(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_timeout(resp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    int          sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] exp_pwdata;
  } txn_t;

  typedef struct {
    logic        err;
    logic        tmo;
    logic [31:0] rdata;
    int          due;
  } resp_t;

  txn_t  bus_q[$];
  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    cyc = 0;
  logic [31:0] model_rdata = '0;
  logic [31:0] model_wdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Slave model: each transfer carries how many wait states the slave inserts
  initial begin
    txn_t cur;
    bit   active;
    int   cnt;
    active = 0;
    cnt = 0;
    cur.sel = 0;
    pready = '0;
    pslverr = '0;
    prdata = '0;
    forever begin
      @(negedge clk);
      pready  = NS'($urandom);
      pslverr = NS'($urandom);
      for (int i = 0; i < NS; i++) prdata[i*32 +: 32] = $urandom;
      if (!reset_n || psel == '0) begin
        active = 0;
      end else if (!penable) begin
        if (bus_q.size() == 0) begin
          check("setup_unexpected", 64'(psel), 64'(0));
          active = 0;
        end else begin
          cur = bus_q.pop_front();
          active = 1;
          cnt = 0;
          check("setup_psel", 64'(psel), 64'(1) << cur.sel);
          check("setup_paddr", 64'(paddr), 64'(cur.addr));
          check("setup_pwrite", 64'(pwrite), 64'(cur.wr));
          check("setup_pstrb", 64'(pstrb), cur.wr ? 64'(cur.strb) : 64'(0));
          check("setup_pwdata", 64'(pwdata), 64'(cur.exp_pwdata));
        end
      end else begin
        check("access_after_setup", 64'(active), 64'(1));
        if (active) begin
          check("access_hold", {23'd0, psel, paddr, pwrite, pstrb},
                {23'd0, NS'(1 << cur.sel), cur.addr, cur.wr, cur.wr ? cur.strb : 4'h0});
          pready[cur.sel]  = (cnt == cur.waits);
          pslverr[cur.sel] = cur.err;
          prdata[cur.sel*32 +: 32] = cur.rdata;
          cnt++;
        end
      end
    end
  end

  // Response monitor
  initial forever begin
    resp_t e;
    @(negedge clk);
    if (reset_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 64'(resp_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("resp_err", 64'(resp_err), 64'(e.err));
        check("resp_timeout", 64'(resp_timeout), 64'(e.tmo));
        check("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
        check("resp_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic issue(input txn_t t, input bit want_resp);
    bit    acc;
    int    guard;
    int    hs;
    resp_t r;
    acc = 0;
    guard = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = t.wr;
    req_sel   = t.sel[SW-1:0];
    req_addr  = t.addr;
    req_wdata = t.wdata;
    req_strb  = t.strb;
    forever begin
      #4;
      acc = req_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      guard++;
      if (guard > 100) begin
        check("accept_bound", 64'(acc), 64'(1));
        break;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (acc) begin
      hs = cyc - 1;
      t.exp_pwdata = t.wr ? t.wdata : model_wdata;
      if (t.sel < NS) begin
        bus_q.push_back(t);
        if (t.wr) model_wdata = t.wdata;
      end
      if (t.sel >= NS) begin
        r.err = 1'b1; r.tmo = 1'b0; r.due = hs + 1;
      end else if (t.waits >= TO) begin
        model_rdata = '0;
        r.err = 1'b1; r.tmo = 1'b1; r.due = hs + 2 + TO;
      end else begin
        if (!t.wr) model_rdata = t.rdata;
        r.err = t.err; r.tmo = 1'b0; r.due = hs + 3 + t.waits;
      end
      r.rdata = model_rdata;
      if (want_resp) exp_q.push_back(r);
    end
  endtask

  function automatic txn_t mk(input logic wr, input int sel, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] strb,
                              input int waits, input logic err, input logic [31:0] rdata);
    txn_t t;
    t.wr = wr; t.sel = sel; t.addr = addr; t.wdata = wdata; t.strb = strb;
    t.waits = waits; t.err = err; t.rdata = rdata; t.exp_pwdata = '0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    int k;
    k = int'($urandom_range(0, 9));
    return mk(1'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3)),
              $urandom, $urandom, 4'($urandom),
              (k < 6) ? int'($urandom_range(0, 3)) : (k < 9) ? int'($urandom_range(4, 15)) : int'($urandom_range(15, 20)),
              ($urandom_range(0, 3) == 0), $urandom);
  endfunction

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int guard;
    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_sel = '0;
    req_addr = '0; req_wdata = '0; req_strb = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_psel", 64'(psel), 64'(0));
    check("rst_penable", 64'(penable), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_bus", {pwrite, paddr, pstrb}, 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("idle_req_ready", 64'(req_ready), 64'(1));

    issue(mk(1, 2, 32'h40, 32'hDEADBEEF, 4'hF, 0, 0, 0), 1);
    drain();
    issue(mk(0, 1, 32'h100, 32'h0, 4'hF, 3, 0, 32'h12345678), 1);
    drain();
    issue(mk(1, 0, 32'h8, 32'hCAFEF00D, 4'h3, 0, 0, 0), 1);
    issue(mk(0, 3, 32'hC, 32'h0, 4'hF, 0, 0, 32'hA5A5A5A5), 1);
    drain();
    issue(mk(0, 1, 32'h20, 32'h0, 4'h0, 1, 1, 32'h0BADF00D), 1);
    issue(mk(0, 0, 32'h24, 32'h0, 4'h0, 15, 0, 32'h15151515), 1);
    drain();
    issue(mk(0, 2, 32'h28, 32'h0, 4'h0, 40, 0, 32'h77777777), 1);
    drain();
    #1;
    check("timeout_psel_clear", 64'(psel), 64'(0));
    issue(mk(1, 4, 32'h30, 32'h11111111, 4'hF, 0, 0, 0), 1);
    issue(mk(0, 7, 32'h34, 32'h0, 4'h0, 0, 0, 0), 1);
    issue(mk(0, 5, 32'h38, 32'h0, 4'h0, 0, 0, 0), 1);
    drain();

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      issue(rand_txn(), 1);
    end
    drain();

    issue(mk(0, 0, 32'h50, 32'h0, 4'h0, 10, 0, 32'h99999999), 0);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!penable && guard < 10);
    check("reach_access", 64'(penable), 64'(1));
    reset_n = 1'b0;
    #1;
    check("midrst_psel", 64'(psel), 64'(0));
    check("midrst_penable", 64'(penable), 64'(0));
    check("midrst_req_ready", 64'(req_ready), 64'(0));
    bus_q.delete();
    model_rdata = '0;
    model_wdata = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    issue(mk(0, 3, 32'h60, 32'h0, 4'h0, 2, 0, 32'h31415926), 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_master_param.md
Name: apb_master_param

Overview:
Parametrised APB4 master, next generation of the single-channel APB master. It accepts transfer requests from the processor side over a valid/ready handshake and drives an APB bus to NUM_SLAVES completers with one-hot select. It adds byte strobes, PSLVERR capture, a wait-state timeout, back-to-back transfers without an IDLE gap, and rejection of invalid slave indices. It sits between the processor bus and the APB peripherals (I2C controller and others).

Parameters:
ADDR_W, 32, APB address width.
DATA_W, 32, data width; must be a multiple of 8.
NUM_SLAVES, 4, number of completers; PSEL width; 1..16.
SEL_W, $clog2(NUM_SLAVES) (min 1), width of the request slave index.
TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables timeout.

Ports:
clk  in  1  clock; all logic is on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  request accepted when valid&ready; combinational.
req_write  in  1  1=write, 0=read.
req_sel  in  SEL_W  target slave index.
req_addr  in  ADDR_W  transfer address.
req_wdata  in  DATA_W  write data.
req_strb  in  DATA_W/8  write byte strobes.
resp_valid  out  1  one-cycle completion pulse; no backpressure.
resp_rdata  out  DATA_W  read data; held until the next response.
resp_err  out  1  error qualifier, valid with resp_valid.
resp_timeout  out  1  timeout qualifier, valid with resp_valid; implies resp_err.
psel  out  NUM_SLAVES  one-hot PSEL.
penable  out  1  PENABLE.
pwrite  out  1  PWRITE.
paddr  out  ADDR_W  PADDR.
pwdata  out  DATA_W  PWDATA.
pstrb  out  DATA_W/8  PSTRB.
prdata  in  NUM_SLAVES*DATA_W  per-slave PRDATA; slave i occupies bits [i*DATA_W +: DATA_W].
pready  in  NUM_SLAVES  per-slave PREADY.
pslverr  in  NUM_SLAVES  per-slave PSLVERR.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, wait counter=0. All registered outputs are 0. req_ready is forced to 0 while reset_n is low.
- States:
  - IDLE: psel=0, penable=0, req_ready=1. When a request is accepted with a valid index, latch it into pwrite, paddr, pwdata and pstrb, set psel one-hot, and go to SETUP.
  - SETUP: psel asserted, penable=0. Always go to ACCESS on the next cycle.
  - ACCESS: penable=1. The selected slave's pready, pslverr and prdata are muxed by the latched index.
- ACCESS completion (selected pready=1):
  - On the next cycle: resp_valid=1, resp_err=selected pslverr, resp_timeout=0.
  - For reads, resp_rdata = selected prdata captured in the completion cycle. For writes, resp_rdata is unchanged.
  - req_ready=1 in the completion cycle. If req_valid=1 there, the new request is latched and the FSM goes directly to SETUP: psel is updated to the new one-hot value and penable drops to 0. Otherwise the FSM goes to IDLE.
- Latency: request accepted in cycle T; SETUP at T+1; ACCESS at T+2; with zero wait states, resp_valid at T+3. Back-to-back throughput is one transfer per 2 cycles.
- Read rule: pstrb is driven to 0 for reads; pwdata keeps its last value for reads.
- Wait counter: counts ACCESS cycles with pready=0 and clears on entry to SETUP. If TIMEOUT_CYCLES>0 and pready is still 0 in the TIMEOUT_CYCLES-th ACCESS cycle:
  - abort; next cycle go to IDLE with psel=0 and penable=0;
  - resp_valid=1, resp_err=1, resp_timeout=1, resp_rdata=0;
  - req_ready=0 in the abort cycle.
- Invalid index (req_sel >= NUM_SLAVES): the request is accepted, but no bus activity occurs. Next cycle: resp_valid=1, resp_err=1, resp_timeout=0, resp_rdata unchanged. FSM stays in IDLE.
- Stability: paddr, pwrite, pwdata and pstrb change only on a transition into SETUP, and hold throughout SETUP and ACCESS.
- pready and pslverr of non-selected slaves are ignored. pslverr is sampled only in the completion cycle.
- Reset asserted mid-transfer: bus outputs return to 0 immediately and no response is generated.

Test Plan:
- Single write, slave 2, addr 0x40, wdata 0xDEADBEEF, strb 0xF, pready tied 1 -> psel=4'b0100 at T+1 with penable=0; penable=1 at T+2; resp_valid at T+3 with resp_err=0.
- Read from slave 1, pready low for 3 ACCESS cycles, prdata=0x12345678 -> penable high for 4 cycles; resp_rdata=0x12345678; pstrb=0 throughout.
- Back-to-back: write slave 0, then read slave 3 with req_valid held -> psel goes 0001 to 1000 with no IDLE cycle; two resp_valid pulses 2 cycles apart.
- pslverr=1 from slave 1 at completion -> resp_err=1, resp_timeout=0.
- TIMEOUT_CYCLES=16, pready never asserted -> abort after 16 ACCESS cycles; resp_err=1, resp_timeout=1, resp_rdata=0; psel=0 next cycle.
- NUM_SLAVES=3 with req_sel=3, then reset_n pulsed low during ACCESS -> first: resp_err=1 with psel never asserted; second: psel and penable clear asynchronously, no resp_valid.
